button_conditioner: RTL and testbench

//  Input-side counterpart of the seven-segment display path: turns raw, bouncing Basys

---
 rtl/button_conditioner.sv | 243 ++++++++++++++++++++++++
 tb/tb_button_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
// Turns raw, bouncing push-buttons into clean clk-synchronous signals.
// Each channel has a synchroniser, a debounce filter, registered press and
// release pulses, and an optional auto-repeat FSM that adds extra press
// pulses while the button stays held.
//
// Reset: rst is asserted asynchronously everywhere. It is released
// synchronously through a two-flop chain that feeds the debounce, edge and
// repeat logic. The input synchroniser flops use rst directly, because they
// are metastability absorbers anyway. The reset chain is two flops deep and
// SYNC_STAGES is at least two, so the debounce logic is already running by
// the time the first synchronised sample arrives. Latency from reset release
// is therefore the same as from any other input change.
module button_conditioner #(
    parameter int                 NUM_BTN         = 5,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_BTN-1:0] REPEAT_EN       = 5'b00110,
    parameter int                 REPEAT_DELAY    = 50000000,
    parameter int                 REPEAT_PERIOD   = 15000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int DCNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST    = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RDELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RPERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    // Auto-repeat FSM states. WAIT covers both "not held" and "held, waiting
    // for the first repeat". RUN means at least one repeat has fired.
    typedef enum logic {
        RPT_WAIT = 1'b0,
        RPT_RUN  = 1'b1
    } rptState_t;

    // ------------------------------------------------------------------
    // Reset release synchroniser
    // ------------------------------------------------------------------
    logic [1:0] rstSyncQ;
    logic       rstSyncN;

    // Assert immediately, release two clock edges after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstSyncQ <= '0;
        end else begin
            rstSyncQ <= {rstSyncQ[0], 1'b1};
        end
    end

    assign rstSyncN = rstSyncQ[1];

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] syncQ [NUM_BTN];
    logic [NUM_BTN-1:0]     syncOut;

    // Shift each raw pin through its own chain of SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                syncQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                syncQ[i] <= {syncQ[i][SYNC_STAGES-2:0], btn_raw[i]};
            end
        end
    end

    // The last flop of each chain is the only view of the pin used downstream.
    always_comb begin
        syncOut = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            syncOut[i] = syncQ[i][SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    logic [DCNT_W-1:0]  dcnt     [NUM_BTN];
    logic [DCNT_W-1:0]  dcntNext [NUM_BTN];
    logic [NUM_BTN-1:0] levelNext;

    // Count consecutive disagreeing samples. Any agreeing sample, such as a
    // bounce back, restarts the count. Accept the new level on the last count.
    always_comb begin
        levelNext = btn_level;
        for (int i = 0; i < NUM_BTN; i++) begin
            dcntNext[i] = dcnt[i];
            if (syncOut[i] == btn_level[i]) begin
                dcntNext[i] = '0;
            end else if (dcnt[i] == DCNT_LAST) begin
                levelNext[i] = syncOut[i];
                dcntNext[i]  = '0;
            end else begin
                dcntNext[i] = dcnt[i] + 1'b1;
            end
        end
    end

    // Debounce counters and accepted level.
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                dcnt[i] <= '0;
            end
            btn_level <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                dcnt[i] <= dcntNext[i];
            end
            btn_level <= levelNext;
        end
    end

    // ------------------------------------------------------------------
    // Level history for edge detection
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] levelD;
    logic [NUM_BTN-1:0] heldQ;

    // levelD is btn_level one cycle later. The edge pulses line up one cycle
    // after a level change. Reset clears levelD together with btn_level, so
    // a reset never produces a release pulse.
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            levelD <= '0;
        end else begin
            levelD <= btn_level;
        end
    end

    // "Held" means the level was high last cycle and is still high. It is
    // false on the rising cycle, so repeat timing starts after the initial
    // press pulse. It is false as soon as the level drops, so no repeat
    // pulse can land on the release cycle.
    assign heldQ = btn_level & levelD;

    // ------------------------------------------------------------------
    // Auto-repeat FSM (one per channel)
    // ------------------------------------------------------------------
    rptState_t          rptState     [NUM_BTN];
    rptState_t          rptStateNext [NUM_BTN];
    logic [RCNT_W-1:0]  rcnt         [NUM_BTN];
    logic [RCNT_W-1:0]  rcntNext     [NUM_BTN];
    logic [NUM_BTN-1:0] repeatTick;

    // State register and repeat counter.
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rptState[i] <= RPT_WAIT;
                rcnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                rptState[i] <= rptStateNext[i];
                rcnt[i]     <= rcntNext[i];
            end
        end
    end

    // Next state. Disabled channels and released buttons park in WAIT with
    // a cleared counter. While held, count to the delay and then to the
    // period, clearing the counter at every repeat.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            rptStateNext[i] = rptState[i];
            rcntNext[i]     = rcnt[i];
            if (!REPEAT_EN[i] || !btn_level[i]) begin
                rptStateNext[i] = RPT_WAIT;
                rcntNext[i]     = '0;
            end else if (heldQ[i]) begin
                case (rptState[i])
                    RPT_WAIT: begin
                        if (rcnt[i] == RDELAY_LAST) begin
                            rptStateNext[i] = RPT_RUN;
                            rcntNext[i]     = '0;
                        end else begin
                            rcntNext[i] = rcnt[i] + 1'b1;
                        end
                    end
                    RPT_RUN: begin
                        if (rcnt[i] == RPERIOD_LAST) begin
                            rcntNext[i] = '0;
                        end else begin
                            rcntNext[i] = rcnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        rptStateNext[i] = RPT_WAIT;
                        rcntNext[i]     = '0;
                    end
                endcase
            end
        end
    end

    // FSM output: a repeat tick on the cycle the active count reaches its
    // terminal value.
    always_comb begin
        repeatTick = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (REPEAT_EN[i] && heldQ[i]) begin
                if ((rptState[i] == RPT_WAIT && rcnt[i] == RDELAY_LAST) ||
                    (rptState[i] == RPT_RUN  && rcnt[i] == RPERIOD_LAST)) begin
                    repeatTick[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered output pulses
    // ------------------------------------------------------------------
    // A press needs btn_level high and a release needs it low, so the two
    // pulses can never be high together on one channel.
    always_ff @(posedge clk or negedge rstSyncN) begin
        if (!rstSyncN) begin
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= (btn_level & ~levelD) | repeatTick;
            btn_release <= ~btn_level & levelD;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Drives directed and randomized button activity. A history-based reference
// model predicts, for every clock edge, the level, press and release outputs.
// Each prediction goes into an expected queue, and a monitor compares the
// queue against the DUT outputs one cycle at a time.
module tb_button_conditioner;

    localparam int NB     = 5;
    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;
    localparam int W      = 3 * NB;

    // ------------------------------------------------------------------
    // Clock and reset
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_EN      (5'b00110),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    // ------------------------------------------------------------------
    // Reference model
    //   r[n]  : raw value driven just before edge n (edge 1 = first after reset)
    //   s[k]  : synchronised value seen by edge k = r[k-SYNC]
    //   The level flips at edge n when s[k] differed from the previous level
    //   for every k in n-DEB+1 .. n.
    //   press at n  : level rose at n-1, or a repeat is due
    //   repeat at n : channel enabled, still high after n-1,
    //                 n - rise - 1 = DELAY + j*PERIOD for some j >= 0
    //   release at n: level fell at n-1
    // ------------------------------------------------------------------
    logic [NB-1:0] rawHist[$];
    logic [NB-1:0] lvlN1 = '0;
    logic [NB-1:0] lvlN2 = '0;
    logic [NB-1:0] renVar = 5'b00110;
    int            edgeN = 0;
    int            riseAt[NB];

    function automatic logic rawBit(input int j, input int ch);
        logic [NB-1:0] v;
        if (j < 1 || j > rawHist.size()) return 1'b0;
        v = rawHist[j-1];
        return v[ch];
    endfunction

    task automatic model_step(input logic rst_val, input logic [NB-1:0] raw);
        logic [NB-1:0] new_lvl;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic          all_diff;
        int            d;
        if (!rst_val) begin
            edgeN = 0;
            rawHist.delete();
            lvlN1 = '0;
            lvlN2 = '0;
            exp_q.push_back('0);
            return;
        end
        edgeN++;
        rawHist.push_back(raw);
        new_lvl = lvlN1;
        press   = lvlN1 & ~lvlN2;
        rel     = ~lvlN1 & lvlN2;
        for (int ch = 0; ch < NB; ch++) begin
            all_diff = 1'b1;
            for (int k = edgeN - DEB + 1; k <= edgeN; k++) begin
                if (rawBit(k - SYNC, ch) == lvlN1[ch]) all_diff = 1'b0;
            end
            if (all_diff) new_lvl[ch] = ~lvlN1[ch];
            if (renVar[ch] && lvlN1[ch]) begin
                d = edgeN - riseAt[ch] - 1 - DELAY;
                if (d >= 0 && (d % PERIOD) == 0) press[ch] = 1'b1;
            end
            if (new_lvl[ch] && !lvlN1[ch]) riseAt[ch] = edgeN;
        end
        lvlN2 = lvlN1;
        lvlN1 = new_lvl;
        exp_q.push_back({new_lvl, press, rel});
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // One clock cycle of stimulus, applied at the falling edge.
    task automatic step(input logic rst_val, input logic [NB-1:0] raw);
        @(negedge clk);
        rst     = rst_val;
        btn_raw = raw;
        model_step(rst_val, raw);
        if (!rst_val) begin
            #1;
            checks++;
            if ({btn_level, btn_press, btn_release} !== '0) begin
                errors++;
                $display("FAIL async_reset @%0t: got lvl=%b press=%b rel=%b, expected all 0",
                         $time, btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic hold(input logic rst_val, input logic [NB-1:0] raw, input int cycles);
        for (int c = 0; c < cycles; c++) step(rst_val, raw);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare every edge against the queued prediction
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {btn_level, btn_press, btn_release};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs @%0t: got lvl=%b press=%b rel=%b, expected lvl=%b press=%b rel=%b",
                             $time, got_v[3*NB-1:2*NB], got_v[2*NB-1:NB], got_v[NB-1:0],
                             exp_v[3*NB-1:2*NB], exp_v[2*NB-1:NB], exp_v[NB-1:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL timeout: stimulus did not complete, got running, expected done");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [NB-1:0] cur;
        int            r;
        int            b;
        for (int i = 0; i < NB; i++) riseAt[i] = 0;

        // Reset with every button held, then keep holding after release.
        hold(1'b0, 5'h1F, 3);
        hold(1'b1, 5'h1F, 12);
        hold(1'b1, 5'h00, 12);

        // Bounce on channel 0, then a stable press.
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00000);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00000);
        hold(1'b1, 5'b00001, 12);
        hold(1'b1, 5'h00, 12);

        // Short glitch on channel 2.
        hold(1'b1, 5'b00100, 3);
        hold(1'b1, 5'h00, 12);

        // Auto-repeat on channel 1.
        hold(1'b1, 5'b00010, 30);
        hold(1'b1, 5'h00, 12);

        // No repeat on channel 4.
        hold(1'b1, 5'b10000, 30);
        hold(1'b1, 5'h00, 12);

        // Simultaneous channels 3 and 0, reset while held, then held again.
        hold(1'b1, 5'b01001, 12);
        hold(1'b0, 5'b01001, 2);
        hold(1'b1, 5'b01001, 12);
        hold(1'b1, 5'h00, 12);

        // Randomized activity with occasional resets.
        cur = '0;
        for (int c = 0; c < 700; c++) begin
            r = $urandom_range(0, 199);
            if (r < 2) begin
                hold(1'b0, cur, $urandom_range(1, 2));
            end else begin
                if (r < 26) begin
                    b = $urandom_range(0, NB - 1);
                    cur[b] = ~cur[b];
                end else if (r < 28) begin
                    cur = NB'($urandom);
                end
                step(1'b1, cur);
            end
        end
        hold(1'b1, 5'h00, 12);

        // Drain the last prediction, then report.
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
